// File: rtl/ge_addsub_seq.sv
// Sequenced Ed25519 extended-coordinate point add/subtract producing the p1p1 result.
// Field multiplies go to a shared external multiplier one at a time; add/sub is limb-wise with no carries.
module ge_addsub_seq #(
   parameter int NLIMB  = 10,
   parameter int LIMB_W = 32,
   localparam int W     = NLIMB * LIMB_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid,
   output logic         ready,
   input  logic [1:0]   mode,
   input  logic [W-1:0] p_x,
   input  logic [W-1:0] p_y,
   input  logic [W-1:0] p_z,
   input  logic [W-1:0] p_t,
   input  logic [W-1:0] q_yplusx,
   input  logic [W-1:0] q_yminusx,
   input  logic [W-1:0] q_t2d,
   input  logic [W-1:0] q_z,
   output logic         mul_req,
   output logic [W-1:0] mul_a,
   output logic [W-1:0] mul_b,
   input  logic         mul_ack,
   input  logic [W-1:0] mul_p,
   output logic [W-1:0] r_x,
   output logic [W-1:0] r_y,
   output logic [W-1:0] r_z,
   output logic [W-1:0] r_t,
   output logic         done
);

   typedef enum logic [2:0] {IDLE, PRE, MUL0, MUL1, MUL2, MUL3, POST, DONE} state_t;

   state_t       state;
   logic [1:0]   mode_q;
   logic [W-1:0] px_q, py_q, pz_q, pt_q;
   logic [W-1:0] qpx_q, qmx_q, q2d_q, qz_q;
   logic [W-1:0] dm_q, a_q, b_q, c_q, d_q;
   logic [W-1:0] t0;
   logic         is_sub;
   logic         is_mixed;

   // Each limb wraps on its own; redundant limb representation is left for the multiplier to reduce.
   function automatic logic [W-1:0] limb_addsub(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic sub);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < NLIMB; i++) begin
         if (sub)
            r[i*LIMB_W +: LIMB_W] = a[i*LIMB_W +: LIMB_W] - b[i*LIMB_W +: LIMB_W];
         else
            r[i*LIMB_W +: LIMB_W] = a[i*LIMB_W +: LIMB_W] + b[i*LIMB_W +: LIMB_W];
      end
      return r;
   endfunction

   assign is_sub   = mode_q[0];
   assign is_mixed = mode_q[1];
   assign t0       = limb_addsub(d_q, d_q, 1'b0);

   // mul_a doubles as the S = Y+X register, since S is only ever consumed as the first operand.
   // The pulse cycle itself is never treated as an ack cycle, hence the !mul_req guard.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ready   <= 1'b1;
         done    <= 1'b0;
         mul_req <= 1'b0;
         mul_a   <= '0;
         mul_b   <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_t     <= '0;
      end else begin
         done    <= 1'b0;
         mul_req <= 1'b0;
         case (state)
            IDLE: begin
               if (valid && ready) begin
                  mode_q <= mode;
                  px_q   <= p_x;
                  py_q   <= p_y;
                  pz_q   <= p_z;
                  pt_q   <= p_t;
                  qpx_q  <= q_yplusx;
                  qmx_q  <= q_yminusx;
                  q2d_q  <= q_t2d;
                  qz_q   <= q_z;
                  ready  <= 1'b0;
                  state  <= PRE;
               end
            end
            PRE: begin
               dm_q    <= limb_addsub(py_q, px_q, 1'b1);
               mul_a   <= limb_addsub(py_q, px_q, 1'b0);
               mul_b   <= is_sub ? qmx_q : qpx_q;
               mul_req <= 1'b1;
               state   <= MUL0;
            end
            MUL0: begin
               if (!mul_req && mul_ack) begin
                  a_q     <= mul_p;
                  mul_a   <= dm_q;
                  mul_b   <= is_sub ? qpx_q : qmx_q;
                  mul_req <= 1'b1;
                  state   <= MUL1;
               end
            end
            MUL1: begin
               if (!mul_req && mul_ack) begin
                  b_q     <= mul_p;
                  mul_a   <= pt_q;
                  mul_b   <= q2d_q;
                  mul_req <= 1'b1;
                  state   <= MUL2;
               end
            end
            MUL2: begin
               if (!mul_req && mul_ack) begin
                  c_q <= mul_p;
                  if (is_mixed) begin
                     d_q   <= pz_q;
                     state <= POST;
                  end else begin
                     mul_a   <= pz_q;
                     mul_b   <= qz_q;
                     mul_req <= 1'b1;
                     state   <= MUL3;
                  end
               end
            end
            MUL3: begin
               if (!mul_req && mul_ack) begin
                  d_q   <= mul_p;
                  state <= POST;
               end
            end
            POST: begin
               r_x   <= limb_addsub(a_q, b_q, 1'b1);
               r_y   <= limb_addsub(a_q, b_q, 1'b0);
               r_z   <= limb_addsub(t0, c_q, is_sub);
               r_t   <= limb_addsub(t0, c_q, !is_sub);
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ge_addsub_seq.sv
// Directed bench for ge_addsub_seq: one 1x16 instance with a 1-cycle multiplier
// and one 2x8 instance with a 5-cycle multiplier to expose limb independence.
module tb_ge_addsub_seq;

   logic        clk = 1'b0;
   logic        rst, valid, sel2;
   logic [1:0]  mode;
   logic [15:0] p_x, p_y, p_z, p_t, q_yplusx, q_yminusx, q_t2d, q_z;
   logic        valid1, valid2;

   logic        ready1, mul_req1, mul_ack1, done1;
   logic [15:0] mul_a1, mul_b1, mul_p1, r_x1, r_y1, r_z1, r_t1;
   logic        ready2, mul_req2, mul_ack2, done2;
   logic [15:0] mul_a2, mul_b2, mul_p2, r_x2, r_y2, r_z2, r_t2;

   logic        ready_s, mul_req_s, done_s;
   logic [15:0] mul_a_s, mul_b_s, r_x_s, r_y_s, r_z_s, r_t_s;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          t_acc, t_first, done_rel, ready_bad;
   int          pulses[$];
   logic [15:0] first_a, first_b;

   int          cnt1 = 0, cnt2 = 0, unstable1 = 0, unstable2 = 0;
   logic [15:0] pa1, pb1, pa2, pb2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign valid1    = valid & ~sel2;
   assign valid2    = valid & sel2;
   assign ready_s   = sel2 ? ready2   : ready1;
   assign mul_req_s = sel2 ? mul_req2 : mul_req1;
   assign done_s    = sel2 ? done2    : done1;
   assign mul_a_s   = sel2 ? mul_a2   : mul_a1;
   assign mul_b_s   = sel2 ? mul_b2   : mul_b1;
   assign r_x_s     = sel2 ? r_x2     : r_x1;
   assign r_y_s     = sel2 ? r_y2     : r_y1;
   assign r_z_s     = sel2 ? r_z2     : r_z1;
   assign r_t_s     = sel2 ? r_t2     : r_t1;

   ge_addsub_seq #(.NLIMB(1), .LIMB_W(16)) dut (
      .clk(clk), .rst(rst), .valid(valid1), .ready(ready1), .mode(mode),
      .p_x(p_x), .p_y(p_y), .p_z(p_z), .p_t(p_t),
      .q_yplusx(q_yplusx), .q_yminusx(q_yminusx), .q_t2d(q_t2d), .q_z(q_z),
      .mul_req(mul_req1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_ack(mul_ack1), .mul_p(mul_p1),
      .r_x(r_x1), .r_y(r_y1), .r_z(r_z1), .r_t(r_t1), .done(done1)
   );

   ge_addsub_seq #(.NLIMB(2), .LIMB_W(8)) dut2 (
      .clk(clk), .rst(rst), .valid(valid2), .ready(ready2), .mode(mode),
      .p_x(p_x), .p_y(p_y), .p_z(p_z), .p_t(p_t),
      .q_yplusx(q_yplusx), .q_yminusx(q_yminusx), .q_t2d(q_t2d), .q_z(q_z),
      .mul_req(mul_req2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_ack(mul_ack2), .mul_p(mul_p2),
      .r_x(r_x2), .r_y(r_y2), .r_z(r_z2), .r_t(r_t2), .done(done2)
   );

   // Multiplier models: ack lands L cycles after the pulse; operands must not move while pending.
   always @(negedge clk) begin
      mul_ack1 = 1'b0;
      if (mul_req1) begin
         cnt1 = 1; pa1 = mul_a1; pb1 = mul_b1;
      end else if (cnt1 > 0) begin
         if (!ready1 && (mul_a1 !== pa1 || mul_b1 !== pb1)) unstable1++;
         cnt1--;
         if (cnt1 == 0) begin mul_ack1 = 1'b1; mul_p1 = pa1 * pb1; end
      end
   end

   always @(negedge clk) begin
      mul_ack2 = 1'b0;
      if (mul_req2) begin
         cnt2 = 5; pa2 = mul_a2; pb2 = mul_b2;
      end else if (cnt2 > 0) begin
         if (!ready2 && (mul_a2 !== pa2 || mul_b2 !== pb2)) unstable2++;
         cnt2--;
         if (cnt2 == 0) begin mul_ack2 = 1'b1; mul_p2 = pa2 * pb2; end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic checkResult(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                              input logic [15:0] t);
      checkOutput("r_x", {16'h0, r_x_s}, {16'h0, x});
      checkOutput("r_y", {16'h0, r_y_s}, {16'h0, y});
      checkOutput("r_z", {16'h0, r_z_s}, {16'h0, z});
      checkOutput("r_t", {16'h0, r_t_s}, {16'h0, t});
   endtask

   // Presents one request, then scrambles the inputs and follows the operation until done
   // (or, when abort_at >= 0, pulses reset at that relative cycle and keeps watching).
   task automatic applyStimulus(input bit use2, input logic [1:0] m,
                                input logic [15:0] px, input logic [15:0] py, input logic [15:0] pz,
                                input logic [15:0] pt, input logic [15:0] qpx, input logic [15:0] qmx,
                                input logic [15:0] q2d, input logic [15:0] qz,
                                input bit hold, input int abort_at);
      int rel;
      sel2 = use2; mode = m;
      p_x = px; p_y = py; p_z = pz; p_t = pt;
      q_yplusx = qpx; q_yminusx = qmx; q_t2d = q2d; q_z = qz;
      valid = 1'b1;
      pulses.delete();
      done_rel = -1; ready_bad = 0;
      for (int w = 0; w < 50 && !ready_s; w++) @(negedge clk);
      if (!ready_s) begin
         checkOutput("ready_wait", 32'd0, 32'd1);
         valid = 1'b0;
         return;
      end
      t_acc = cyc;
      for (int k = 1; k < 200; k++) begin
         @(negedge clk);
         rel = cyc - t_acc;
         if (k == 1) begin
            valid = hold; mode = ~m;
            p_x = 16'hA5A5; p_y = 16'h5A5A; p_z = 16'h1234; p_t = 16'h4321;
            q_yplusx = 16'hBEEF; q_yminusx = 16'hCAFE; q_t2d = 16'hF00D; q_z = 16'h7777;
         end
         rst = (rel == abort_at);
         if (mul_req_s) begin
            if (pulses.size() == 0) begin first_a = mul_a_s; first_b = mul_b_s; end
            pulses.push_back(rel);
         end
         if (ready_s) ready_bad++;
         if (done_s) begin done_rel = rel; break; end
         if (abort_at >= 0 && rel >= abort_at + 15) break;
      end
      rst = 1'b0;
      if (abort_at < 0) checkOutput("done_seen", {31'h0, done_rel >= 0}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; sel2 = 1'b0; mode = 2'b00;
      p_x = '0; p_y = '0; p_z = '0; p_t = '0;
      q_yplusx = '0; q_yminusx = '0; q_t2d = '0; q_z = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", {31'h0, ready1}, 32'd1);
      checkOutput("rst_done", {31'h0, done1}, 32'd0);
      checkOutput("rst_mul_req", {31'h0, mul_req1}, 32'd0);
      checkOutput("rst_mul_a", {16'h0, mul_a1}, 32'd0);
      checkResult(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] ADD");
      applyStimulus(1'b0, 2'b00, 16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd1, 1'b0, -1);
      checkOutput("add_done_at", done_rel, 32'd11);
      checkOutput("add_pulses", pulses.size(), 32'd4);
      if (pulses.size() == 4) begin
         checkOutput("add_pulse0", pulses[0], 32'd2);
         checkOutput("add_pulse1", pulses[1], 32'd4);
         checkOutput("add_pulse2", pulses[2], 32'd6);
         checkOutput("add_pulse3", pulses[3], 32'd8);
      end
      checkResult(16'h0000, 16'h0030, 16'h0019, 16'hFFEF);
      @(negedge clk);
      checkOutput("add_done_single", {31'h0, done1}, 32'd0);
      checkOutput("add_ready_back", {31'h0, ready1}, 32'd1);

      $display("[TB] SUB");
      applyStimulus(1'b0, 2'b01, 16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd1, 1'b0, -1);
      checkOutput("sub_done_at", done_rel, 32'd11);
      checkResult(16'h0014, 16'h0034, 16'hFFEF, 16'h0019);

      $display("[TB] MADD");
      applyStimulus(1'b0, 2'b10, 16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd9, 1'b0, -1);
      checkOutput("madd_done_at", done_rel, 32'd9);
      checkOutput("madd_pulses", pulses.size(), 32'd3);
      checkResult(16'h0000, 16'h0030, 16'h0019, 16'hFFEF);

      $display("[TB] limb independence, slow multiplier");
      applyStimulus(1'b1, 2'b00, 16'h0101, 16'h01FF, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd1, 1'b0, -1);
      checkOutput("carry_first_a", {16'h0, first_a}, 32'h0200);
      checkOutput("carry_first_b", {16'h0, first_b}, 32'h0004);
      checkOutput("carry_done_at", done_rel, 32'd27);
      checkOutput("carry_pulses", pulses.size(), 32'd4);
      if (pulses.size() == 4) checkOutput("carry_pulse1", pulses[1], 32'd8);
      checkOutput("carry_operands_stable", unstable2, 32'd0);
      checkResult(16'h030C, 16'h0DF4, 16'h0019, 16'h00EF);

      $display("[TB] reset during MUL2");
      applyStimulus(1'b0, 2'b00, 16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd1, 1'b0, 6);
      checkOutput("abort_no_done", done_rel, 32'hFFFF_FFFF);
      checkOutput("abort_pulses", pulses.size(), 32'd3);
      checkOutput("abort_ready", {31'h0, ready1}, 32'd1);
      checkOutput("abort_mul_req", {31'h0, mul_req1}, 32'd0);
      checkResult(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      applyStimulus(1'b0, 2'b00, 16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd1, 1'b0, -1);
      checkOutput("after_abort_done_at", done_rel, 32'd11);
      checkResult(16'h0000, 16'h0030, 16'h0019, 16'hFFEF);

      $display("[TB] back-to-back with valid held");
      applyStimulus(1'b0, 2'b00, 16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd1, 1'b1, -1);
      t_first = t_acc;
      checkOutput("b2b_first_done_at", done_rel, 32'd11);
      checkOutput("b2b_ready_low", ready_bad, 32'd0);
      checkResult(16'h0000, 16'h0030, 16'h0019, 16'hFFEF);
      applyStimulus(1'b0, 2'b01, 16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd1, 1'b0, -1);
      checkOutput("b2b_accept_at", t_acc - t_first, 32'd12);
      checkOutput("b2b_second_done_at", done_rel, 32'd11);
      checkResult(16'h0014, 16'h0034, 16'hFFEF, 16'h0019);
      checkOutput("operands_stable", unstable1, 32'd0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
